if_fetch_buf: RTL

- Instruction-fetch front end, directly upstream of the IF/ID register and decode.
- Owns the PC, issues word fetches to instruction memory, and buffers returned instructions with their PC+4 in a small FIFO.
- Presents one instruction per cycle to decode over a valid/ready handshake.
- Accepts redirects (branch/jump) from decode, which flush the queue and any stale in-flight fetches.

---
 rtl/if_pkg.sv | 17 +
 rtl/if_fetch_buf_chk.sv | 22 ++
 rtl/if_fetch_buf_sync_fifo.sv | 65 ++++++
 rtl/if_fetch_buf.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

   localparam logic [29:0] RESET_PC_DEFAULT = 30'h0000_0C00;
   localparam logic [31:0] NOP_INS          = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] ins;
      logic [29:0] pc_plus_4;
   } entry_t;

   // Word-address increment; wraps naturally at 30 bits.
   function automatic logic [29:0] pc_inc(input logic [29:0] pc);
      return pc + 30'd1;
   endfunction

endpackage

// File: rtl/if_fetch_buf_chk.sv
// Invariant checker for if_fetch_buf: credit, tag tracking and overflow properties.
module if_fetch_buf_chk #(
   parameter int OW = 2
) (
   input logic          clk,
   input logic          rst,
   input logic          resp_keep,
   input logic          ent_full,
   input logic          tag_empty,
   input logic          tag_full,
   input logic          imem_req,
   input logic [OW-1:0] tag_count,
   input logic [OW-1:0] outstanding,
   input logic [OW-1:0] drop_cnt
);

   a_no_full_arrival: assert property (@(posedge clk) disable iff (!rst) !(resp_keep && ent_full));
   a_tag_available:   assert property (@(posedge clk) disable iff (!rst) !(resp_keep && tag_empty));
   a_tag_room:        assert property (@(posedge clk) disable iff (!rst) !(imem_req && tag_full));
   a_tag_tracks:      assert property (@(posedge clk) disable iff (!rst) tag_count == outstanding - drop_cnt);

endmodule

// File: rtl/if_fetch_buf_sync_fifo.sv
// Synchronous FIFO with clear; push on full is accepted only when paired with a pop.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      if (p == AW'(DEPTH - 1)) begin
         return {AW{1'b0}};
      end else begin
         return p + AW'(1'b1);
      end
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == CW'(0));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // Storage, pointers and occupancy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= {AW{1'b0}};
         wr_ptr <= {AW{1'b0}};
         count  <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= {WIDTH{1'b0}};
         end
      end else if (clear) begin
         rd_ptr <= {AW{1'b0}};
         wr_ptr <= {AW{1'b0}};
         count  <= {CW{1'b0}};
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/if_fetch_buf.sv
// Fetch front end: PC, imem request credit, prefetch FIFO and redirect flush.
// Optional saturating statistics counters under `ifdef IF_FETCH_STAT_EN.
module if_fetch_buf
   import if_pkg::*;
#(
   parameter int          DEPTH     = 4,
   parameter int          MAX_OUTST = 2,
   parameter logic [29:0] RESET_PC  = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [29:0] redirect_pc,
   output logic        imem_req,
   output logic [29:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_ins,
   output logic [29:0] id_PC_plus_4
`ifdef IF_FETCH_STAT_EN
   ,
   output logic [31:0] stat_fetched,
   output logic [31:0] stat_stall,
   output logic [15:0] stat_flush
`endif
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int OW = $clog2(MAX_OUTST) + 1;
   localparam int SW = CW + 1;

   logic [29:0]   fetch_pc;
   logic [OW-1:0] outstanding;
   logic [OW-1:0] drop_cnt;
   logic [CW-1:0] count;
   logic [OW-1:0] tag_count;
   logic [SW-1:0] inflight;
   logic [29:0]   tag_pc;
   logic          resp_keep;
   logic          id_fire;
   logic          ent_full;
   logic          ent_empty;
   logic          tag_full;
   logic          tag_empty;
   entry_t        ent_wdata;
   entry_t        ent_head;

   // Entries held plus live (non-dropped) requests must leave room for every response.
   assign inflight  = SW'(count) + SW'(outstanding) - SW'(drop_cnt);
   assign imem_req  = rst && !redirect_valid && (outstanding < OW'(MAX_OUTST)) && (inflight < SW'(DEPTH));
   assign imem_addr = fetch_pc;
   assign resp_keep = imem_rvalid && (drop_cnt == OW'(0)) && !redirect_valid;
   assign id_valid  = !ent_empty;
   assign id_fire   = id_valid && id_ready;
   assign ent_wdata = '{ins: imem_rdata, pc_plus_4: pc_inc(tag_pc)};
   assign id_ins       = id_valid ? ent_head.ins : NOP_INS;
   assign id_PC_plus_4 = id_valid ? ent_head.pc_plus_4 : 30'd0;

   // Fetch PC plus outstanding/drop accounting; redirect turns live requests into drops
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc    <= RESET_PC;
         outstanding <= OW'(0);
         drop_cnt    <= OW'(0);
      end else if (redirect_valid) begin
         fetch_pc    <= redirect_pc;
         outstanding <= outstanding - OW'(imem_rvalid);
         drop_cnt    <= outstanding - OW'(imem_rvalid);
      end else begin
         if (imem_req) begin
            fetch_pc <= pc_inc(fetch_pc);
         end
         outstanding <= outstanding + OW'(imem_req) - OW'(imem_rvalid);
         if (imem_rvalid && (drop_cnt != OW'(0))) begin
            drop_cnt <= drop_cnt - OW'(1'b1);
         end
      end
   end

   sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_entry_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (redirect_valid),
      .push  (resp_keep),
      .pop   (id_fire),
      .wdata (ent_wdata),
      .rdata (ent_head),
      .count (count),
      .full  (ent_full),
      .empty (ent_empty)
   );

   sync_fifo #(.WIDTH(30), .DEPTH(MAX_OUTST)) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (redirect_valid),
      .push  (imem_req),
      .pop   (resp_keep),
      .wdata (fetch_pc),
      .rdata (tag_pc),
      .count (tag_count),
      .full  (tag_full),
      .empty (tag_empty)
   );

   if_fetch_buf_chk #(.OW(OW)) u_chk (
      .clk         (clk),
      .rst         (rst),
      .resp_keep   (resp_keep),
      .ent_full    (ent_full),
      .tag_empty   (tag_empty),
      .tag_full    (tag_full),
      .imem_req    (imem_req),
      .tag_count   (tag_count),
      .outstanding (outstanding),
      .drop_cnt    (drop_cnt)
   );

`ifdef IF_FETCH_STAT_EN
   // Saturating counters: accepted handshakes, starved decode cycles, redirects
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_fetched <= 32'd0;
         stat_stall   <= 32'd0;
         stat_flush   <= 16'd0;
      end else begin
         if (id_fire && (stat_fetched != 32'hFFFF_FFFF)) begin
            stat_fetched <= stat_fetched + 32'd1;
         end
         if (id_ready && !id_valid && (stat_stall != 32'hFFFF_FFFF)) begin
            stat_stall <= stat_stall + 32'd1;
         end
         if (redirect_valid && (stat_flush != 16'hFFFF)) begin
            stat_flush <= stat_flush + 16'd1;
         end
      end
   end
`endif

endmodule
